// File: rtl/mux_stream_n1.sv
// mux_stream_n1 -- parametrised N:1 streaming multiplexer with a one-entry
// registered output stage and valid/ready handshake on every channel.
//
// Optional feature macro: MUX_STREAM_RR_EN
//   defined   : round-robin arbiter and pointer are built; inMode selects
//               fixed-select (0) or round-robin (1) channel choice.
//   undefined : fixed-select only; inMode is ignored.
//
// Ports:
//   inClk      clock, rising edge
//   inRst      asynchronous active-high reset
//   inData     NB_CH*WIDTH packed channel data, channel k at [k*WIDTH +: WIDTH]
//   inValid    per-channel valid
//   outReady   per-channel ready (only the active channel can be high)
//   inSel      requested channel for fixed mode
//   inSelLoad  load inSel into the select register (out-of-range ignored)
//   inMode     0 = fixed select, 1 = round-robin (RR builds only)
//   outData    registered output word
//   outValid   outData valid
//   inReady    downstream ready
//   outSel     channel index of the word held in outData
module mux_stream_n1 #(
    parameter  int NB_CH = 4,
    parameter  int WIDTH = 4,
    localparam int SEL_W = $clog2(NB_CH)
) (
    input  logic                   inClk,
    input  logic                   inRst,
    input  logic [NB_CH*WIDTH-1:0] inData,
    input  logic [NB_CH-1:0]       inValid,
    output logic [NB_CH-1:0]       outReady,
    input  logic [SEL_W-1:0]       inSel,
    input  logic                   inSelLoad,
    input  logic                   inMode,
    output logic [WIDTH-1:0]       outData,
    output logic                   outValid,
    input  logic                   inReady,
    output logic [SEL_W-1:0]       outSel
);

    localparam int unsigned    NB     = NB_CH;
    localparam logic [SEL_W:0] NB_LIM = (SEL_W+1)'(NB_CH);

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] active;
    logic [WIDTH-1:0] data_sel;
    logic             acc;
    logic             xfer;
    logic             sel_ok;

    assign acc    = !outValid || inReady;
    assign sel_ok = {1'b0, inSel} < NB_LIM;

`ifdef MUX_STREAM_RR_EN
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] grant;
    logic             found;
    int unsigned      idx;

    // Cyclic search starting just after the last granted channel; with no
    // valid channel the grant parks on ptr+1 so ready is still offered there.
    always_comb begin
        found = 1'b0;
        idx   = 0;
        grant = SEL_W'((32'(ptr_q) + 32'd1) % NB);
        for (int unsigned i = 1; i <= NB; i++) begin
            idx = (32'(ptr_q) + i) % NB;
            if (!found && inValid[idx[SEL_W-1:0]]) begin
                grant = idx[SEL_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign active = inMode ? grant : sel_q;

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            ptr_q <= SEL_W'(NB_CH - 1);
        end else if (xfer && inMode) begin
            ptr_q <= active;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = inMode;
    assign active      = sel_q;
`endif

    always_comb begin
        outReady = '0;
        data_sel = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            if (active == SEL_W'(k)) begin
                outReady[k] = acc && !inRst;
                data_sel    = inData[k*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(outReady & inValid);

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            outData  <= '0;
            outValid <= 1'b0;
            outSel   <= '0;
        end else if (acc) begin
            if (xfer) begin
                outData  <= data_sel;
                outSel   <= active;
                outValid <= 1'b1;
            end else begin
                outValid <= 1'b0;
            end
        end
    end

    // A load in the same cycle as a transfer only affects the next cycle,
    // because active is taken from the register value before this edge.
    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            sel_q <= '0;
        end else if (inSelLoad && sel_ok) begin
            sel_q <= inSel;
        end
    end

endmodule

// File: tb/tb_mux_stream_n1.sv
module tb_mux_stream_n1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  vld;
    logic [1:0]  sel;
    logic        load, mode, ready;

    logic [3:0] r4;
    logic [3:0] d4;
    logic       v4;
    logic [1:0] s4;
    logic [2:0] r3;
    logic [3:0] d3;
    logic       v3;
    logic [1:0] s3;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state, index 0 = 4-channel instance, 1 = 3-channel instance
    int nbv[2] = '{4, 3};
    int m_valid[2], m_data[2], m_sel[2], m_selreg[2], m_p[2];

    always #5 clk = ~clk;

    mux_stream_n1 #(.NB_CH(4), .WIDTH(4)) dut (
        .inClk(clk), .inRst(rst), .inData(data), .inValid(vld), .outReady(r4),
        .inSel(sel), .inSelLoad(load), .inMode(mode), .outData(d4),
        .outValid(v4), .inReady(ready), .outSel(s4)
    );

    mux_stream_n1 #(.NB_CH(3), .WIDTH(4)) dut3 (
        .inClk(clk), .inRst(rst), .inData(data[11:0]), .inValid(vld[2:0]),
        .outReady(r3), .inSel(sel), .inSelLoad(load), .inMode(mode),
        .outData(d3), .outValid(v3), .inReady(ready), .outSel(s3)
    );

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d]  = 0;
            m_data[d]   = 0;
            m_sel[d]    = 0;
            m_selreg[d] = 0;
            m_p[d]      = nbv[d] - 1;
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 0, 32'(v4), 32'(m_valid[0]));
        chk("out_data",  0, 32'(d4), 32'(m_data[0]));
        chk("out_sel",   0, 32'(s4), 32'(m_sel[0]));
        chk("out_valid", 1, 32'(v3), 32'(m_valid[1]));
        chk("out_data",  1, 32'(d3), 32'(m_data[1]));
        chk("out_sel",   1, 32'(s3), 32'(m_sel[1]));
    endtask

    // Called at a falling edge: drive, check ready, advance model, check outputs.
    task automatic step(input logic [3:0] v, input logic [15:0] dt, input logic [1:0] s,
                        input logic ld, input logic md, input logic rdy);
        int  nb, a, acc, xfer, rr, exp_ready, c;
        bit  found;
        logic [31:0] obs_ready;
        vld = v; data = dt; sel = s; load = ld; mode = md; ready = rdy;
        #1;
        for (int d = 0; d < 2; d++) begin
            nb  = nbv[d];
`ifdef MUX_STREAM_RR_EN
            rr  = int'(md);
`else
            rr  = 0;
`endif
            acc = (m_valid[d] == 0 || rdy) ? 1 : 0;
            if (rr != 0) begin
                a = (m_p[d] + 1) % nb;
                found = 0;
                for (int i = 1; i <= nb; i++) begin
                    c = (m_p[d] + i) % nb;
                    if (!found && v[c]) begin a = c; found = 1; end
                end
            end else begin
                a = m_selreg[d];
            end
            exp_ready = acc ? (1 << a) : 0;
            obs_ready = (d == 0) ? 32'(r4) : 32'(r3);
            chk("out_ready", d, obs_ready, 32'(exp_ready));
            xfer = (acc != 0 && v[a]) ? 1 : 0;
            if (acc != 0) begin
                if (xfer != 0) begin
                    m_valid[d] = 1;
                    m_data[d]  = (int'(dt) >> (a * 4)) & 15;
                    m_sel[d]   = a;
                    if (rr != 0) m_p[d] = a;
                end else begin
                    m_valid[d] = 0;
                end
            end
            if (ld && int'(s) < nb) m_selreg[d] = int'(s);
        end
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; data = '0; vld = '0; sel = '0; load = 1'b0; mode = 1'b0; ready = 1'b0;
        model_reset();
        #3;
        check_outputs();
        chk("ready_in_reset", 0, 32'(r4), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // fixed mode: load select 2; transfer uses old select this cycle
        step(4'b0100, 16'h0A00, 2'd2, 1'b1, 1'b0, 1'b1);
        step(4'b0100, 16'h0A00, 2'd2, 1'b0, 1'b0, 1'b1);
        step(4'b0100, 16'h0B00, 2'd0, 1'b0, 1'b0, 1'b1);
        // back-pressure for three cycles, then release
        step(4'b0100, 16'h0C00, 2'd0, 1'b0, 1'b0, 1'b0);
        step(4'b0100, 16'h0C00, 2'd0, 1'b0, 1'b0, 1'b0);
        step(4'b0100, 16'h0C00, 2'd0, 1'b0, 1'b0, 1'b0);
        step(4'b0100, 16'h0C00, 2'd0, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 16'h0D00, 2'd0, 1'b0, 1'b0, 1'b1);
        // sel 3: valid on 4-channel instance, ignored on 3-channel instance
        step(4'b1111, 16'h9876, 2'd3, 1'b1, 1'b0, 1'b1);
        step(4'b1111, 16'h5432, 2'd0, 1'b0, 1'b0, 1'b1);
        step(4'b1111, 16'h1234, 2'd0, 1'b0, 1'b0, 1'b1);
        // mode 1 with select 1 (round-robin only when built in)
        step(4'b1111, 16'hFEDC, 2'd1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b1111, 16'(i * 16'h1111), 2'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b1010, 16'(16'hA5C3 + i), 2'd0, 1'b0, 1'b1, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), 16'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0),
                 1'($urandom), ($urandom_range(0, 9) < 7));
        end

        // reset mid-stream with a word stalled in the output register
        step(4'b0111, 16'h0777, 2'd0, 1'b0, 1'b1, 1'b1);
        step(4'b0111, 16'h0777, 2'd0, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("ready_in_reset", 0, 32'(r4), 32'd0);
        chk("ready_in_reset", 1, 32'(r3), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(4'b1111, 16'h4321, 2'd0, 1'b0, 1'b1, 1'b1);
        step(4'b0010, 16'h00F0, 2'd1, 1'b1, 1'b0, 1'b1);
        step(4'b0010, 16'h00E0, 2'd1, 1'b0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
